// File: rtl/fifo_wr_ptr_full_pkg.sv
// Shared sizing defaults and flag bundle for the async FIFO write-side pointer stage.
package fifo_wr_ptr_full_pkg;

    localparam int A_LENGTH_DEF  = 3;
    localparam int AF_MARGIN_DEF = 2;
    localparam int PTR_W_DEF     = A_LENGTH_DEF + 1;
    localparam int DEPTH_DEF     = 1 << A_LENGTH_DEF;

    // Registered status flags presented to the write-side producer.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic wr_ack;
        logic overflow;
    } wr_flags_t;

endpackage

// File: rtl/fifo_wr_ptr_full_sync.sv
// Two-flop synchronizer for a gray-coded pointer crossing into the local clock domain.
module ptr_sync_2ff #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [1:0][width-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= d;
            stage[1] <= stage[0];
        end
    end

    assign q = stage[1];

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer, gray export, read-pointer sync and full/almost_full/ack/overflow flags.
module fifo_wr_ptr_full
    import fifo_wr_ptr_full_pkg::*;
#(
    parameter int a_length  = A_LENGTH_DEF,
    parameter int AF_MARGIN = AF_MARGIN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [a_length:0] rd_gray_in,
    output logic [a_length-1:0] wr_addr,
    output logic [a_length:0] wr_gray_out,
    output logic              full,
    output logic              almost_full,
    output logic              wr_ack,
    output logic              overflow
);

    localparam int PTR_W = a_length + 1;
    localparam int DEPTH = 1 << a_length;
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_MARGIN);

    logic [PTR_W-1:0] wbin, wbin_next, gray_next;
    logic [PTR_W-1:0] rq2, rbin_s, fill_next, full_pattern;
    logic             wr_fire;
    wr_flags_t        flags_q, flags_d;

    ptr_sync_2ff #(.width(PTR_W)) u_rd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rd_gray_in),
        .q     (rq2)
    );

    always_comb begin
        rbin_s           = '0;
        rbin_s[a_length] = rq2[a_length];
        for (int i = a_length - 1; i >= 0; i--) begin
            rbin_s[i] = rq2[i] ^ rbin_s[i+1];
        end
    end

    // Writes are judged against the registered full only; freed space arrives via sync latency.
    assign wr_fire   = wr_en & ~flags_q.full;
    assign wbin_next = wbin + PTR_W'(wr_fire);
    assign gray_next = wbin_next ^ (wbin_next >> 1);
    assign fill_next = wbin_next - rbin_s;

    // Gray of a pointer exactly DEPTH ahead differs in the top two bits only.
    assign full_pattern = {~rq2[a_length:a_length-1], rq2[a_length-2:0]};

    always_comb begin
        flags_d             = '0;
        flags_d.full        = (gray_next == full_pattern);
        flags_d.almost_full = (fill_next >= AF_THRESH);
        flags_d.wr_ack      = wr_fire;
        flags_d.overflow    = wr_en & flags_q.full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wr_gray_out <= '0;
            flags_q     <= '0;
        end else begin
            wbin        <= wbin_next;
            wr_gray_out <= gray_next;
            flags_q     <= flags_d;
        end
    end

    assign wr_addr     = wbin[a_length-1:0];
    assign full        = flags_q.full;
    assign almost_full = flags_q.almost_full;
    assign wr_ack      = flags_q.wr_ack;
    assign overflow    = flags_q.overflow;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Directed bench for fifo_wr_ptr_full with a fill-level model checked every cycle.
module tb_fifo_wr_ptr_full;

    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [A:0]   rd_gray_in = '0;
    logic [A-1:0] wr_addr;
    logic [A:0]   wr_gray_out;
    logic         full, almost_full, wr_ack, overflow;

    int checks = 0;
    int errors = 0;

    fifo_wr_ptr_full #(.a_length(A), .AF_MARGIN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_gray_in  (rd_gray_in),
        .wr_addr     (wr_addr),
        .wr_gray_out (wr_gray_out),
        .full        (full),
        .almost_full (almost_full),
        .wr_ack      (wr_ack),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = g[i] ^ b[i+1];
        return b;
    endfunction

    // Occupancy after this edge: writes so far minus reads the write side can see.
    function automatic logic [3:0] lvl(input logic [3:0] w, input logic f, input logic [3:0] rg);
        return w + {3'b000, f} - g2b(rg);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: write count, read pointer seen two edges late, history for read tracking.
    logic [3:0] m_w, m_wprev, rh1, rh2;
    logic [3:0] wh [0:3];
    logic       m_full, m_af, m_ack, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_w <= '0; m_wprev <= '0; rh1 <= '0; rh2 <= '0;
            m_full <= 1'b0; m_af <= 1'b0; m_ack <= 1'b0; m_ovf <= 1'b0;
            for (int i = 0; i < 4; i++) wh[i] <= '0;
        end else begin
            m_wprev <= m_w;
            m_w     <= m_w + {3'b000, wr_en && !m_full};
            m_full  <= lvl(m_w, wr_en && !m_full, rh2) == 4'd8;
            m_af    <= lvl(m_w, wr_en && !m_full, rh2) >= 4'd6;
            m_ack   <= wr_en && !m_full;
            m_ovf   <= wr_en && m_full;
            rh1     <= rd_gray_in;
            rh2     <= rh1;
            wh[0]   <= m_w;
            for (int i = 1; i < 4; i++) wh[i] <= wh[i-1];
        end
    end

    always @(negedge clk) begin
        chk("gray", {4'h0, wr_gray_out}, {4'h0, b2g(m_w)});
        chk("addr", {5'h0, wr_addr}, {5'h0, m_w[2:0]});
        chk("full", {7'h0, full}, {7'h0, m_full});
        chk("almost_full", {7'h0, almost_full}, {7'h0, m_af});
        chk("wr_ack", {7'h0, wr_ack}, {7'h0, m_ack});
        chk("overflow", {7'h0, overflow}, {7'h0, m_ovf});
        if (rst_n)
            chk("gray_step_bits", 8'($countones(wr_gray_out ^ b2g(m_wprev))), m_ack ? 8'd1 : 8'd0);
    end

    task automatic step(input logic we);
        wr_en = we;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_g [0:7] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100};
    logic [3:0] rd_b;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_gray", {4'h0, wr_gray_out}, 8'h00);
        chk("rst_flags", {4'h0, full, almost_full, wr_ack, overflow}, 8'h00);
        rst_n = 1'b1;

        // 1: fill from empty
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            chk("t1_gray", {4'h0, wr_gray_out}, {4'h0, exp_g[i]});
            chk("t1_ack", {7'h0, wr_ack}, 8'h01);
            chk("t1_af", {7'h0, almost_full}, (i >= 5) ? 8'h01 : 8'h00);
            chk("t1_full", {7'h0, full}, (i == 7) ? 8'h01 : 8'h00);
        end

        // 2: writes while full
        for (int i = 0; i < 2; i++) begin
            step(1'b1);
            chk("t2_gray", {4'h0, wr_gray_out}, 8'h0c);
            chk("t2_ovf_ack", {6'h0, overflow, wr_ack}, 8'h02);
        end
        step(1'b0);
        chk("t2_ovf_clear", {7'h0, overflow}, 8'h00);

        // 3: one read frees a slot after three edges
        rd_gray_in = 4'b0001;
        step(1'b0);
        chk("t3_full_e1", {7'h0, full}, 8'h01);
        step(1'b0);
        chk("t3_full_e2", {7'h0, full}, 8'h01);
        step(1'b0);
        chk("t3_full_e3", {7'h0, full}, 8'h00);
        step(1'b1);
        chk("t3_gray", {4'h0, wr_gray_out}, 8'h0d);
        chk("t3_refull", {7'h0, full}, 8'h01);
        step(1'b0);

        // 4: reads trail writes, pointer wraps
        rd_gray_in = '0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            rd_gray_in = b2g(wh[3]);
            step(1'b1);
            chk("t4_nofull", {7'h0, full}, 8'h00);
            if (i == 14) chk("t4_gray_top", {4'h0, wr_gray_out}, 8'h08);
            if (i == 15) chk("t4_gray_wrap", {4'h0, wr_gray_out}, 8'h00);
            if (i == 15) chk("t4_addr_wrap", {5'h0, wr_addr}, 8'h00);
        end

        // 5: asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) step(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_gray", {4'h0, wr_gray_out}, 8'h00);
        chk("t5_rst_addr", {5'h0, wr_addr}, 8'h00);
        chk("t5_rst_flags", {4'h0, full, almost_full, wr_ack, overflow}, 8'h00);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_gray_in = '0;
        step(1'b1);
        chk("t5_first_gray", {4'h0, wr_gray_out}, 8'h01);
        step(1'b0);

        // 6: random read walk with random writes
        do_reset();
        rd_b = '0;
        for (int i = 0; i < 80; i++) begin
            if ((m_w - rd_b) != 4'd0 && $urandom_range(0, 2) != 0) rd_b = rd_b + 4'd1;
            rd_gray_in = b2g(rd_b);
            step(1'($urandom_range(0, 3) != 0));
        end
        step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
